// File: rtl/soft_max_row_feeder.sv
// Row sequencer for the SOFT_MAX engine: buffers one score row, streams it once for the
// denominator accumulation, replays it for the numerator pass, then waits for all results.
module soft_max_row_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_NUM   = 4,
    parameter int INFO_WIDTH = 20,
    parameter int MAX_BEATS  = 16,
    localparam int AW        = $clog2(MAX_BEATS) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [AW-1:0]                  row_beats,
    input  logic [7:0]                     row_tag,
    input  logic                           in_vld,
    input  logic [DATA_NUM*DATA_WIDTH-1:0] in_data,
    output logic                           in_rdy,
    output logic                           sum_clear,
    output logic                           denomintor_in_vld,
    output logic                           numerator_in_vld,
    output logic [DATA_NUM*DATA_WIDTH-1:0] denomintor_in,
    output logic [DATA_NUM*DATA_WIDTH-1:0] numerator_in,
    output logic [INFO_WIDTH-1:0]          soft_max_info_in,
    input  logic                           denomintor_sum_ok,
    input  logic                           sm_out_vld,
    output logic                           busy,
    output logic                           row_done
);

    localparam int DW = DATA_NUM * DATA_WIDTH;
    localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [AW-1:0] ONE   = AW'(1);
    localparam logic [AW-1:0] MAX_B = AW'(MAX_BEATS);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_CLEAR    = 3'd2;
    localparam logic [2:0] S_DEN      = 3'd3;
    localparam logic [2:0] S_WAIT_SUM = 3'd4;
    localparam logic [2:0] S_NUM      = 3'd5;
    localparam logic [2:0] S_DRAIN    = 3'd6;

    logic [2:0]    state;
    logic [AW-1:0] beats;
    logic [7:0]    tag;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] out_cnt;
    logic [DW-1:0] row_mem [MAX_BEATS];

    logic          load_fire;
    logic          load_last;
    logic          rd_last;
    logic [AW-1:0] rd_nxt;
    logic [AW-1:0] cnt_nxt;
    logic          start_ok;

    function automatic logic [INFO_WIDTH-1:0] info_word(input logic [AW-1:0] idx,
                                                        input logic last,
                                                        input logic [7:0] t);
        return {(INFO_WIDTH-16)'(0), last, 7'(idx), t};
    endfunction

    assign in_rdy    = (state == S_LOAD);
    assign busy      = (state != S_IDLE);
    assign load_fire = in_rdy && in_vld;
    assign load_last = load_fire && (wr_idx == beats - ONE);
    assign rd_last   = (rd_idx == beats - ONE);
    assign rd_nxt    = rd_idx + ONE;
    assign start_ok  = start && (row_beats != '0) && (row_beats <= MAX_B);

    // Result beats may start arriving during the replay; the count saturates at the row length.
    assign cnt_nxt = ((state == S_NUM || state == S_DRAIN) && sm_out_vld && (out_cnt != beats))
                     ? out_cnt + ONE : out_cnt;

    // NOTE: the row buffer has no reset; every entry read in a pass was written in LOAD first.
    always_ff @(posedge clk) begin
        if (load_fire) row_mem[wr_idx[BW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            beats             <= '0;
            tag               <= '0;
            wr_idx            <= '0;
            rd_idx            <= '0;
            out_cnt           <= '0;
            sum_clear         <= 1'b0;
            denomintor_in_vld <= 1'b0;
            numerator_in_vld  <= 1'b0;
            denomintor_in     <= '0;
            numerator_in      <= '0;
            soft_max_info_in  <= '0;
            row_done          <= 1'b0;
        end else begin
            sum_clear <= 1'b0;
            row_done  <= 1'b0;
            out_cnt   <= cnt_nxt;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        beats  <= row_beats;
                        tag    <= row_tag;
                        wr_idx <= '0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_fire) wr_idx <= wr_idx + ONE;
                    if (load_last) begin
                        sum_clear <= 1'b1;
                        out_cnt   <= '0;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    denomintor_in_vld <= 1'b1;
                    denomintor_in     <= row_mem[0];
                    soft_max_info_in  <= info_word('0, beats == ONE, tag);
                    rd_idx            <= '0;
                    state             <= S_DEN;
                end
                S_DEN: begin
                    if (rd_last) begin
                        denomintor_in_vld <= 1'b0;
                        denomintor_in     <= '0;
                        soft_max_info_in  <= '0;
                        rd_idx            <= '0;
                        state             <= S_WAIT_SUM;
                    end else begin
                        rd_idx           <= rd_nxt;
                        denomintor_in    <= row_mem[rd_nxt[BW-1:0]];
                        soft_max_info_in <= info_word(rd_nxt, rd_nxt == beats - ONE, tag);
                    end
                end
                S_WAIT_SUM: begin
                    if (denomintor_sum_ok) begin
                        numerator_in_vld <= 1'b1;
                        numerator_in     <= row_mem[0];
                        soft_max_info_in <= info_word('0, beats == ONE, tag);
                        rd_idx           <= '0;
                        state            <= S_NUM;
                    end
                end
                S_NUM: begin
                    if (rd_last) begin
                        numerator_in_vld <= 1'b0;
                        numerator_in     <= '0;
                        soft_max_info_in <= '0;
                        rd_idx           <= '0;
                        state            <= S_DRAIN;
                    end else begin
                        rd_idx           <= rd_nxt;
                        numerator_in     <= row_mem[rd_nxt[BW-1:0]];
                        soft_max_info_in <= info_word(rd_nxt, rd_nxt == beats - ONE, tag);
                    end
                end
                S_DRAIN: begin
                    // Looking at cnt_nxt lets the final result beat raise row_done on the next cycle.
                    if (cnt_nxt == beats) begin
                        row_done <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soft_max_row_feeder.sv
// Directed bench for soft_max_row_feeder: full rows of several lengths, gapped loading,
// illegal starts, stray handshakes and a mid-replay reset.
module tb_soft_max_row_feeder;

    localparam int DATA_WIDTH = 16;
    localparam int DATA_NUM   = 4;
    localparam int INFO_WIDTH = 20;
    localparam int MAX_BEATS  = 16;
    localparam int AW         = $clog2(MAX_BEATS) + 1;
    localparam int DW         = DATA_WIDTH * DATA_NUM;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [AW-1:0]         row_beats = '0;
    logic [7:0]            row_tag = '0;
    logic                  in_vld = 1'b0;
    logic [DW-1:0]         in_data = '0;
    logic                  in_rdy;
    logic                  sum_clear;
    logic                  denomintor_in_vld;
    logic                  numerator_in_vld;
    logic [DW-1:0]         denomintor_in;
    logic [DW-1:0]         numerator_in;
    logic [INFO_WIDTH-1:0] soft_max_info_in;
    logic                  denomintor_sum_ok = 1'b0;
    logic                  sm_out_vld = 1'b0;
    logic                  busy;
    logic                  row_done;

    int n_checks = 0;
    int n_errors = 0;

    soft_max_row_feeder #(
        .DATA_WIDTH(DATA_WIDTH),
        .DATA_NUM  (DATA_NUM),
        .INFO_WIDTH(INFO_WIDTH),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .row_beats        (row_beats),
        .row_tag          (row_tag),
        .in_vld           (in_vld),
        .in_data          (in_data),
        .in_rdy           (in_rdy),
        .sum_clear        (sum_clear),
        .denomintor_in_vld(denomintor_in_vld),
        .numerator_in_vld (numerator_in_vld),
        .denomintor_in    (denomintor_in),
        .numerator_in     (numerator_in),
        .soft_max_info_in (soft_max_info_in),
        .denomintor_sum_ok(denomintor_sum_ok),
        .sm_out_vld       (sm_out_vld),
        .busy             (busy),
        .row_done         (row_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_val(input int row, input int k);
        return {16'(16'h1000 * row + k), 16'(16'hA5A0 + k), 16'(row * 37 + k * 5), 16'(k)};
    endfunction

    // Expected info: [15]=last beat, [14:8]=beat index, [7:0]=row tag.
    function automatic logic [63:0] exp_info(input int k, input int beats, input logic [7:0] t);
        logic [19:0] w;
        w = {4'h0, (k == beats - 1) ? 1'b1 : 1'b0, 7'(k), t};
        return 64'(w);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_rdy"},   in_rdy, 0);
        check({tag, "_vld"},   {sum_clear, denomintor_in_vld, numerator_in_vld, row_done}, 0);
        check({tag, "_bus"},   denomintor_in | numerator_in, 0);
        check({tag, "_info"},  soft_max_info_in, 0);
    endtask

    task automatic run_row(input int row, input int beats, input logic [7:0] rtag,
                           input bit gap, input int wait_cyc, input bit stray, input bit abort);
        int ov;
        bit bad;
        string p;
        p = $sformatf("r%0d", row);
        ov = (beats >= 4) ? 2 : 0;

        start = 1'b1; row_beats = AW'(beats); row_tag = rtag;
        step();
        start = 1'b0;
        check({p, "_start_busy"}, busy, 1);
        check({p, "_start_rdy"}, in_rdy, 1);

        for (int k = 0; k < beats; k++) begin
            if (gap) begin
                in_vld = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    if (k == 1 && g == 0) begin
                        start = 1'b1; row_beats = AW'(1); row_tag = 8'hFF;
                    end
                    step();
                    start = 1'b0;
                end
            end
            if (k == 0 || k == beats - 1) check({p, "_load_rdy"}, in_rdy, 1);
            in_vld = 1'b1; in_data = beat_val(row, k);
            step();
        end
        in_vld = 1'b0; in_data = '0; row_tag = rtag;
        check({p, "_clear"}, sum_clear, 1);
        check({p, "_clear_info"}, soft_max_info_in, 0);
        check({p, "_clear_rdy"}, in_rdy, 0);
        step();
        check({p, "_clear_once"}, sum_clear, 0);

        for (int k = 0; k < beats; k++) begin
            check($sformatf("%s_den_vld%0d", p, k), {denomintor_in_vld, numerator_in_vld}, 2'b10);
            check($sformatf("%s_den_dat%0d", p, k), denomintor_in, beat_val(row, k));
            check($sformatf("%s_den_inf%0d", p, k), soft_max_info_in, exp_info(k, beats, rtag));
            if (stray && k == 0) denomintor_sum_ok = 1'b1;
            step();
            denomintor_sum_ok = 1'b0;
        end
        check({p, "_den_end"}, {denomintor_in_vld, numerator_in_vld}, 0);
        check({p, "_den_end_dat"}, denomintor_in, 0);

        bad = 1'b0;
        for (int w = 0; w < wait_cyc; w++) begin
            if (denomintor_in_vld || numerator_in_vld || sum_clear || row_done || !busy) bad = 1'b1;
            if (soft_max_info_in != '0) bad = 1'b1;
            sm_out_vld = stray && (w == 0);
            step();
        end
        sm_out_vld = 1'b0;
        check({p, "_wait_quiet"}, bad, 0);
        check({p, "_wait_num"}, numerator_in_vld, 0);

        denomintor_sum_ok = 1'b1;
        step();
        denomintor_sum_ok = 1'b0;

        for (int k = 0; k < beats; k++) begin
            check($sformatf("%s_num_vld%0d", p, k), {denomintor_in_vld, numerator_in_vld}, 2'b01);
            check($sformatf("%s_num_dat%0d", p, k), numerator_in, beat_val(row, k));
            check($sformatf("%s_num_inf%0d", p, k), soft_max_info_in, exp_info(k, beats, rtag));
            if (abort) begin
                rst = 1'b1;
                #1;
                check_idle_outputs({p, "_abort"});
                #2;
                rst = 1'b0;
                step();
                check_idle_outputs({p, "_after_abort"});
                return;
            end
            sm_out_vld = (k >= beats - ov);
            step();
        end
        sm_out_vld = 1'b0;
        check({p, "_num_end"}, numerator_in_vld, 0);
        check({p, "_num_end_dat"}, numerator_in, 0);

        for (int j = 0; j < beats - ov; j++) begin
            check($sformatf("%s_drain_early%0d", p, j), row_done, 0);
            sm_out_vld = 1'b1;
            step();
        end
        sm_out_vld = 1'b0;
        if (beats - ov == 0) step();
        check({p, "_row_done"}, row_done, 1);
        check({p, "_done_busy"}, busy, 0);
        step();
        check({p, "_done_pulse"}, row_done, 0);
    endtask

    initial begin
        #3;
        check_idle_outputs("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        step();
        check_idle_outputs("reset_rel");

        run_row(1, 4, 8'h2A, 1'b0, 3, 1'b0, 1'b0);
        run_row(2, 1, 8'h2A, 1'b0, 2, 1'b0, 1'b0);
        run_row(3, 5, 8'h55, 1'b1, 50, 1'b1, 1'b0);
        run_row(4, MAX_BEATS, 8'h7F, 1'b0, 1, 1'b0, 1'b0);

        start = 1'b1; row_beats = AW'(0); row_tag = 8'h11;
        step();
        start = 1'b0;
        check_idle_outputs("illegal_zero");
        start = 1'b1; row_beats = AW'(MAX_BEATS + 1);
        step();
        start = 1'b0;
        check_idle_outputs("illegal_over");
        step();
        check({"illegal_stay"}, busy, 0);

        run_row(5, 4, 8'h33, 1'b0, 2, 1'b0, 1'b1);
        run_row(6, 3, 8'h44, 1'b0, 2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
